// File: rtl/vid_read_sequencer.sv
// Time-slot RAM read sequencer feeding a chain of MAGGIE address generators.
// Optional host read/write slot: define VID_READ_SEQUENCER_HOST_PORT_EN.
module vid_read_sequencer #(
    parameter int PORTS      = 4,
    parameter int ADDR_SIZE  = 20,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 pc_ena_in,
    input  logic [PORTS*ADDR_SIZE-1:0] read_addr_in,
    output logic [PORTS*16-1:0]        ram_dout,
    output logic [ADDR_SIZE-1:0]       ram_addr,
    input  logic [15:0]                ram_din,
    output logic                       ram_wena,
    output logic [15:0]                ram_wdata
`ifdef VID_READ_SEQUENCER_HOST_PORT_EN
    ,
    input  logic                       host_req,
    input  logic                       host_wr,
    input  logic [ADDR_SIZE-1:0]       host_addr,
    input  logic [15:0]                host_wdata,
    output logic                       host_ack,
    output logic [15:0]                host_rdata
`endif
);

    if (PORTS < 1 || PORTS > 8) begin : g_bad_ports
        $error("vid_read_sequencer: PORTS must be 1..8");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
        $error("vid_read_sequencer: PIPE_DEPTH must be 1..8");
    end
    if (PORTS + PIPE_DEPTH > 15) begin : g_bad_sum
        $error("vid_read_sequencer: PORTS + PIPE_DEPTH must be <= 15");
    end

    typedef struct packed {
        logic       valid;
        logic [3:0] id;
    } tag_t;

    tag_t                  tags [PIPE_DEPTH];
    tag_t                  new_tag;
    tag_t                  tag_out;
    logic                  issue;
    logic [ADDR_SIZE-1:0]  issue_addr;
    logic [ADDR_SIZE-1:0]  cli_addr;
    logic                  cli_hit;
    logic [PORTS*16-1:0]   shadow;

    assign tag_out = tags[PIPE_DEPTH-1];

    always_comb begin
        cli_hit  = 1'b0;
        cli_addr = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (pc_ena_in == 4'(k)) begin
                cli_hit  = 1'b1;
                cli_addr = read_addr_in[k*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

`ifdef VID_READ_SEQUENCER_HOST_PORT_EN
    localparam logic [3:0] HOST_ID = 4'(PORTS);

    logic host_go;
    logic host_wr_go;
    logic host_cap;

    assign host_go    = host_req && (pc_ena_in == 4'(PORTS));
    assign host_wr_go = host_go && host_wr;
    assign host_cap   = tag_out.valid && (tag_out.id == HOST_ID);

    always_comb begin
        issue         = cli_hit;
        issue_addr    = cli_addr;
        new_tag.valid = cli_hit;
        new_tag.id    = pc_ena_in;
        if (host_go) begin
            issue      = 1'b1;
            issue_addr = host_addr;
            // Writes complete at issue, so they never occupy the tag pipe.
            if (!host_wr) begin
                new_tag.valid = 1'b1;
                new_tag.id    = HOST_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_wena   <= 1'b0;
            ram_wdata  <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            ram_wena <= host_wr_go;
            host_ack <= host_wr_go || host_cap;
            if (host_wr_go) begin
                ram_wdata <= host_wdata;
            end
            if (host_cap) begin
                host_rdata <= ram_din;
            end
        end
    end
`else
    always_comb begin
        issue         = cli_hit;
        issue_addr    = cli_addr;
        new_tag.valid = cli_hit;
        new_tag.id    = pc_ena_in;
    end

    assign ram_wena  = 1'b0;
    assign ram_wdata = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                tags[i] <= '0;
            end
            ram_addr <= '0;
            shadow   <= '0;
            ram_dout <= '0;
        end else begin
            tags[0] <= new_tag;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                tags[i] <= tags[i-1];
            end
            if (issue) begin
                ram_addr <= issue_addr;
            end
            for (int k = 0; k < PORTS; k++) begin
                if (tag_out.valid && tag_out.id == 4'(k)) begin
                    shadow[k*16 +: 16] <= ram_din;
                end
            end
            // Last client capture lands at slot 14, so commit sees a full set.
            if (pc_ena_in == 4'd15) begin
                ram_dout <= shadow;
            end
        end
    end

endmodule
